// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_chunk_adder
//  Purpose  : Multi-cycle adder/subtractor. WIDTH-bit operands are summed
//             CHUNK bits per clock, with a registered carry between chunks.
//             Reports unsigned carry-out and signed overflow, and uses a
//             start/busy/done handshake.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - operation request, sampled in IDLE or DONE
//             sub    - 0: a+b, 1: a-b (sampled with start)
//             a, b   - WIDTH-bit operands (sampled with start)
//             busy   - operation in progress
//             done   - one-cycle pulse, sum/cout/ovf freshly valid
//             sum    - WIDTH-bit result, held until the next completion
//             cout   - carry out of the MSB (for sub: 1 = no borrow)
//             ovf    - signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4      // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] c_last = IDXW'(NCHUNK - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    int               w_base;
    logic [CHUNK-1:0] w_a_chk;
    logic [CHUNK-1:0] w_b_chk;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_c_msb;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_base  = int'(r_idx) * CHUNK;
    assign w_a_chk = r_opa[w_base +: CHUNK];
    assign w_b_chk = r_opb[w_base +: CHUNK];
    assign w_last  = (r_idx == c_last);

    // One chunk of ripple addition, one bit wider to expose the carry.
    assign {w_c, w_s} = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};

    // Carry into the top bit of the chunk, recovered from the sum bit:
    // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. On the last chunk this is the
    // carry into the word MSB; it also covers CHUNK = 1 (cin = r_carry).
    assign w_c_msb = w_s[CHUNK-1] ^ w_a_chk[CHUNK-1] ^ w_b_chk[CHUNK-1];

    always_comb begin
        w_res_next                   = r_res;
        w_res_next[w_base +: CHUNK]  = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: the +1 rides in on the carry.
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_ovf   <= w_c ^ w_c_msb;
                        r_state <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
